// File: rtl/mem_resp_if.sv
// Single 64-bit memory port between the arbiter (master) and the memory responder (slave).
interface mem_resp_if;
  logic [63:0] addr_m;
  logic [63:0] dout_m;
  logic        req_m;
  logic        wr_m;
  logic [63:0] din_m;
  logic        rdy_m;

  modport master (output addr_m, dout_m, req_m, wr_m, input  din_m, rdy_m);
  modport slave  (input  addr_m, dout_m, req_m, wr_m, output din_m, rdy_m);
endinterface

// File: rtl/mem_resp.sv
// Memory responder: DEPTH x 64-bit array, one outstanding transaction, one rdy_m pulse
// per transaction after a fixed LATENCY of wait cycles.
module mem_resp #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_resp_if.slave   bus,
  output logic        busy,
  output logic        err
);
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, RESP, GAP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic          oor_q, oor_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          rdy_q, rdy_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [63:0]   mem [DEPTH];

  logic [AW-1:0] addr_idx;
  logic          addr_oor;
  logic [AW-1:0] rd_idx;
  logic          rd_oor, rd_wr, go_resp;
  logic          unused_lsb;

  assign addr_idx   = bus.addr_m[AW+2:3];
  assign addr_oor   = |bus.addr_m[63:AW+3];
  assign unused_lsb = ^bus.addr_m[2:0];

  // With zero latency the response is prepared in ARM, before capture lands in the _q regs.
  assign rd_idx = (state_q == ARM) ? addr_idx  : idx_q;
  assign rd_oor = (state_q == ARM) ? addr_oor  : oor_q;
  assign rd_wr  = (state_q == ARM) ? bus.wr_m  : wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    oor_d   = oor_q;
    wdata_d = wdata_q;
    rdy_d   = 1'b0;
    rdata_d = 64'd0;
    err_d   = err_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (bus.req_m) state_d = ARM;
      ARM: begin
        if (!bus.req_m) begin
          state_d = IDLE;
        end else begin
          idx_d   = addr_idx;
          wr_d    = bus.wr_m;
          oor_d   = addr_oor;
          wdata_d = bus.dout_m;
          cnt_d   = 4'd0;
          if (LATENCY == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // rdy/din/err are registered, so they are computed on the edge entering RESP.
    if (go_resp) begin
      rdy_d = 1'b1;
      if (rd_oor)      err_d   = 1'b1;
      else if (!rd_wr) rdata_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      wdata_q <= 64'd0;
      rdy_q   <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write commits on the edge ending RESP; a reset in RESP cancels it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && wr_q && !oor_q)
      mem[idx_q] <= wdata_q;
  end

  assign bus.rdy_m = rdy_q;
  assign bus.din_m = rdata_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: a LATENCY=2 and a LATENCY=0 instance, directed cases then random traffic
// checked against a word-array model.
module tb_mem_resp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        req  [2];
  logic        wr   [2];
  logic [63:0] addr [2];
  logic [63:0] wdat [2];
  logic        rdy_w  [2];
  logic [63:0] din_w  [2];
  logic        busy_w [2];
  logic        err_w  [2];

  mem_resp_if bus0();
  mem_resp_if bus1();

  assign bus0.req_m  = req[0];
  assign bus0.wr_m   = wr[0];
  assign bus0.addr_m = addr[0];
  assign bus0.dout_m = wdat[0];
  assign bus1.req_m  = req[1];
  assign bus1.wr_m   = wr[1];
  assign bus1.addr_m = addr[1];
  assign bus1.dout_m = wdat[1];
  assign rdy_w[0] = bus0.rdy_m;
  assign din_w[0] = bus0.din_m;
  assign rdy_w[1] = bus1.rdy_m;
  assign din_w[1] = bus1.din_m;

  mem_resp #(.AW(10), .LATENCY(2)) dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0.slave), .busy(busy_w[0]), .err(err_w[0]));
  mem_resp #(.AW(10), .LATENCY(0)) dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1.slave), .busy(busy_w[1]), .err(err_w[1]));

  // reference model
  logic [63:0] mdl [2][1024];
  bit          wrt [2][1024];
  bit          err_exp [2];
  int          lat [2] = '{2, 0};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go_idle(input int d);
    int k = 0;
    @(negedge clk);
    while (busy_w[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", 64'(busy_w[d]), 64'd0);
  endtask

  // counts cycles from the request cycle (cycle 0) to the rdy_m cycle
  task automatic wait_rdy(input int d, input bit scr, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!rdy_w[d]) begin
        chk("din_idle", din_w[d], 64'd0);
        if (scr && n >= 2) begin
          addr[d] = {$urandom, $urandom};
          wdat[d] = {$urandom, $urandom};
          wr[d]   = 1'($urandom_range(0, 1));
          req[d]  = 1'($urandom_range(0, 1));
        end
      end
    end while (!rdy_w[d] && n < 40);
  endtask

  task automatic txn(input int d, input bit w, input logic [63:0] a, input logic [63:0] data,
                     output logic [63:0] got);
    int n;
    int idx;
    bit oor;
    go_idle(d);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdat[d] = data;
    wait_rdy(d, 1'b1, n);
    got = din_w[d];
    chk("latency", 64'(n), 64'(lat[d] + 2));
    chk("busy_resp", 64'(busy_w[d]), 64'd1);
    oor = (a[63:13] != 0);
    idx = int'(a[12:3]);
    if (oor) begin
      chk("oor_din", got, 64'd0);
      err_exp[d] = 1'b1;
    end else if (w) begin
      chk("wr_din", got, 64'd0);
      mdl[d][idx] = data;
      wrt[d][idx] = 1'b1;
    end else if (wrt[d][idx]) begin
      chk("rd_data", got, mdl[d][idx]);
    end
    req[d] = 1'b0;
    @(posedge clk); #1;
    chk("rdy_once", 64'(rdy_w[d]), 64'd0);
    chk("din_after", din_w[d], 64'd0);
    chk("err", 64'(err_w[d]), 64'(err_exp[d]));
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] a;
    int n1, n2;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 64'd0; wdat[d] = 64'd0;
      err_exp[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy",  64'(rdy_w[d]),  64'd0);
      chk("rst_din",  din_w[d],       64'd0);
      chk("rst_busy", 64'(busy_w[d]), 64'd0);
      chk("rst_err",  64'(err_w[d]),  64'd0);
      rst[d] = 1'b0;
    end

    // write then read back at LATENCY=2
    txn(0, 1'b1, 64'h40, 64'hDEADBEEF_00000001, got);
    txn(0, 1'b0, 64'h47, 64'h0, got);
    chk("t1_rd", got, 64'hDEADBEEF_00000001);

    // request withdrawn in ARM: no transaction, memory untouched
    go_idle(0);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 64'h40; wdat[0] = 64'h1234;
    @(posedge clk); #1;
    chk("arm_busy", 64'(busy_w[0]), 64'd1);
    req[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_rdy",  64'(rdy_w[0]),  64'd0);
      chk("abort_busy", 64'(busy_w[0]), 64'd0);
    end
    txn(0, 1'b0, 64'h40, 64'h0, got);
    chk("abort_mem", got, 64'hDEADBEEF_00000001);

    // top in-range index and first out-of-range index
    txn(0, 1'b1, 64'h1FF8, 64'hA5A5_0000_FFFF_1111, got);
    txn(0, 1'b0, 64'h1FF8, 64'h0, got);
    chk("top_idx", got, 64'hA5A5_0000_FFFF_1111);
    txn(0, 1'b0, 64'h2000, 64'h0, got);
    chk("oor_err", 64'(err_w[0]), 64'd1);
    txn(0, 1'b1, 64'h2000, 64'h5555, got);
    txn(0, 1'b0, 64'h0, 64'h0, got);
    chk("oor_drop", 64'(wrt[0][0]), 64'd0);
    chk("err_sticky", 64'(err_w[0]), 64'd1);

    // req held across rdy_m: GAP ignores it, then a second transaction
    go_idle(0);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 64'h40;
    wait_rdy(0, 1'b0, n1);
    chk("hold_lat1", 64'(n1), 64'(lat[0] + 2));
    chk("hold_d1", din_w[0], 64'hDEADBEEF_00000001);
    wait_rdy(0, 1'b0, n2);
    chk("hold_gap", 64'(n2), 64'(lat[0] + 4));
    chk("hold_d2", din_w[0], 64'hDEADBEEF_00000001);
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("hold_once", 64'(rdy_w[0]), 64'd0);

    // reset in WAIT of a write: no rdy, no commit, err cleared
    txn(0, 1'b1, 64'h8, 64'h0BAD_F00D_0000_0008, got);
    go_idle(0);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 64'h8; wdat[0] = 64'hFFFF_EEEE_DDDD_CCCC;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    err_exp[0] = 1'b0;
    chk("rst_wait_busy", 64'(busy_w[0]), 64'd0);
    chk("rst_wait_err",  64'(err_w[0]),  64'd0);
    repeat (5) begin
      chk("rst_wait_rdy", 64'(rdy_w[0]), 64'd0);
      @(posedge clk); #1;
    end
    txn(0, 1'b0, 64'h8, 64'h0, got);
    chk("rst_wait_mem", got, 64'h0BAD_F00D_0000_0008);

    // LATENCY=0 build
    txn(1, 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, got);
    txn(1, 1'b0, 64'h40, 64'h0, got);
    chk("l0_rd", got, 64'h0123_4567_89AB_CDEF);

    // random traffic on both builds
    for (int i = 0; i < 120; i++) begin
      int d = i % 2;
      a = {51'd0, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7))} << 5'd0;
      a = {51'd0, a[12:0]};
      a[12:3] = 10'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[13 + $urandom_range(0, 50)] = 1'b1;
      txn(d, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, got);
    end

    // reset clears err on both
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk("final_err0", 64'(err_w[0]), 64'd0);
    chk("final_err1", 64'(err_w[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
